// File: rtl/data_mem_ctrl_if.sv
// Word-wide req/ack data-memory bus between the load/store controller
// (master) and the data memory (slave).
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 30
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store responder: turns one decoded load or store into a single req/ack
// bus transaction, stalls the core meanwhile and flags bad or timed-out accesses.
module data_mem_ctrl #(
    parameter int ADDR_W  = 30,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [1:0]             AU_inst_sel,
    input  logic                   signed_inst,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   stall,
    output logic                   acc_err,
    data_mem_ctrl_if.master        bus
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        tcnt_q, tcnt_d;

    logic        access;
    logic        illegal;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;
    logic [31:0] load_c;

    assign access  = mem_read | mem_write;
    assign illegal = (mem_read & mem_write)
                   | (AU_inst_sel == 2'b11)
                   | ((AU_inst_sel == SZ_HALF) & addr[0])
                   | ((AU_inst_sel == SZ_WORD) & (addr[1:0] != 2'b00));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        case (AU_inst_sel)
            SZ_BYTE: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_c    = 4'b0011 << addr[1:0];
                wdata_c = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane selection uses the address/size latched at acceptance, not the live inputs.
    always_comb begin
        byte_c = bus.mem_rdata[7:0];
        case (lane_q)
            2'd1:    byte_c = bus.mem_rdata[15:8];
            2'd2:    byte_c = bus.mem_rdata[23:16];
            2'd3:    byte_c = bus.mem_rdata[31:24];
            default: byte_c = bus.mem_rdata[7:0];
        endcase
        half_c = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_c = {{24{sgn_q & byte_c[7]}}, byte_c};
            SZ_HALF: load_c = {{16{sgn_q & half_c[15]}}, half_c};
            default: load_c = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        lane_d  = lane_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (illegal) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = BUS;
                        err_d   = 1'b0;
                        req_d   = 1'b1;
                        we_d    = mem_write;
                        addr_d  = addr[ADDR_W+1:2];
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        size_d  = AU_inst_sel;
                        sgn_d   = signed_inst;
                        lane_d  = addr[1:0];
                        tcnt_d  = '0;
                    end
                end
            end
            BUS: begin
                if (bus.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) rdata_d = load_c;
                end else if (tcnt_q == TO_LAST) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            lane_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            lane_q  <= lane_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // rst_n gates stall so a core holding its request through reset is not frozen.
    assign stall   = rst_n & (((state_q == IDLE) & access) | (state_q == BUS));
    assign acc_err = (state_q == DONE) & err_q;
    assign rdata   = rdata_q;

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl: one task per scenario,
// memory side driven by hand from the stimulus.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  AU_inst_sel = 2'b00;
    logic        signed_inst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        acc_err;

    int n_chk = 0;
    int n_pass = 0;

    data_mem_ctrl_if #(.ADDR_W(30)) bus ();

    data_mem_ctrl #(.ADDR_W(30), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .AU_inst_sel(AU_inst_sel),
        .signed_inst(signed_inst),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .acc_err    (acc_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sel,
                         input logic sgn, input logic [31:0] a, input logic [31:0] wd);
        mem_read    = rd;
        mem_write   = wr;
        AU_inst_sel = sel;
        signed_inst = sgn;
        addr        = a;
        wdata       = wd;
    endtask

    task automatic release_core();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", bus.mem_req); else n_pass++;
        n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.mem_we); else n_pass++;
        n_chk++; if (bus.mem_addr !== 30'h0) $display("FAIL rst_addr: got %h want 0", bus.mem_addr); else n_pass++;
        n_chk++; if (bus.mem_be !== 4'h0) $display("FAIL rst_be: got %b want 0000", bus.mem_be); else n_pass++;
        n_chk++; if (bus.mem_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); else n_pass++;
        n_chk++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rdata); else n_pass++;
        n_chk++; if (acc_err !== 1'b0) $display("FAIL rst_err: got %b want 0", acc_err); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL idle_stall: got %b want 0", stall); else n_pass++;
    endtask

    task automatic test_lw();
        @(negedge clk);
        bus.mem_rdata = 32'hDEADBEEF;
        bus.mem_ack = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL lw_stall_idle: got %b want 1", stall); else n_pass++;
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL lw_req_idle: got %b want 0", bus.mem_req); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.mem_req !== 1'b1) $display("FAIL lw_req: got %b want 1", bus.mem_req); else n_pass++;
        n_chk++; if (bus.mem_addr !== 30'h40) $display("FAIL lw_addr: got %h want 40", bus.mem_addr); else n_pass++;
        n_chk++; if (bus.mem_be !== 4'b1111) $display("FAIL lw_be: got %b want 1111", bus.mem_be); else n_pass++;
        n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL lw_we: got %b want 0", bus.mem_we); else n_pass++;
        n_chk++; if (stall !== 1'b1) $display("FAIL lw_stall_bus: got %b want 1", stall); else n_pass++;
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL lw_stall_done: got %b want 0", stall); else n_pass++;
        n_chk++; if (rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata: got %h want deadbeef", rdata); else n_pass++;
        n_chk++; if (acc_err !== 1'b0) $display("FAIL lw_err: got %b want 0", acc_err); else n_pass++;
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL lw_req_done: got %b want 0", bus.mem_req); else n_pass++;
        release_core();
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_lb();
        @(negedge clk);
        bus.mem_rdata = 32'h80FFFF00;
        bus.mem_ack = 1'b1;
        drive(1'b1, 1'b0, 2'b10, 1'b1, 32'h103, 32'h0);
        @(negedge clk);
        n_chk++; if (bus.mem_be !== 4'b1000) $display("FAIL lb_be: got %b want 1000", bus.mem_be); else n_pass++;
        n_chk++; if (bus.mem_addr !== 30'h40) $display("FAIL lb_addr: got %h want 40", bus.mem_addr); else n_pass++;
        @(negedge clk);
        n_chk++; if (rdata !== 32'hFFFFFF80) $display("FAIL lb_rdata: got %h want ffffff80", rdata); else n_pass++;
        n_chk++; if (acc_err !== 1'b0) $display("FAIL lb_err: got %b want 0", acc_err); else n_pass++;
        release_core();
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (rdata !== 32'h00000080) $display("FAIL lbu_rdata: got %h want 00000080", rdata); else n_pass++;
        release_core();
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_sh();
        @(negedge clk);
        bus.mem_rdata = 32'hFFFFFFFF;
        bus.mem_ack = 1'b1;
        drive(1'b0, 1'b1, 2'b01, 1'b1, 32'h22, 32'h1234ABCD);
        @(negedge clk);
        n_chk++; if (bus.mem_req !== 1'b1) $display("FAIL sh_req: got %b want 1", bus.mem_req); else n_pass++;
        n_chk++; if (bus.mem_we !== 1'b1) $display("FAIL sh_we: got %b want 1", bus.mem_we); else n_pass++;
        n_chk++; if (bus.mem_be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", bus.mem_be); else n_pass++;
        n_chk++; if (bus.mem_wdata !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h want abcdabcd", bus.mem_wdata); else n_pass++;
        n_chk++; if (bus.mem_addr !== 30'h8) $display("FAIL sh_addr: got %h want 8", bus.mem_addr); else n_pass++;
        @(negedge clk);
        n_chk++; if (rdata !== 32'h00000080) $display("FAIL sh_rdata_kept: got %h want 00000080", rdata); else n_pass++;
        n_chk++; if (acc_err !== 1'b0) $display("FAIL sh_err: got %b want 0", acc_err); else n_pass++;
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL sh_req_done: got %b want 0", bus.mem_req); else n_pass++;
        release_core();
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_lh_wait();
        int sc;
        @(negedge clk);
        bus.mem_rdata = 32'h80011234;
        bus.mem_ack = 1'b0;
        drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        sc = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (!stall) break;
            sc++;
            @(negedge clk);
            if (sc == 3) bus.mem_ack = 1'b1;
        end
        n_chk++; if (sc !== 4) $display("FAIL lh_stall_cycles: got %0d want 4", sc); else n_pass++;
        n_chk++; if (rdata !== 32'hFFFF8001) $display("FAIL lh_rdata: got %h want ffff8001", rdata); else n_pass++;
        release_core();
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.mem_ack = 1'b0;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (bus.mem_req !== 1'b1) $display("FAIL rmid_req_before: got %b want 1", bus.mem_req); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL rmid_req: got %b want 0", bus.mem_req); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL rmid_stall: got %b want 0", stall); else n_pass++;
        n_chk++; if (rdata !== 32'h0) $display("FAIL rmid_rdata: got %h want 0", rdata); else n_pass++;
        @(negedge clk);
        release_core();
        rst_n = 1'b1;
        @(negedge clk);
        bus.mem_rdata = 32'hCAFEF00D;
        bus.mem_ack = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h104, 32'h0);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL rmid_new_stall: got %b want 1", stall); else n_pass++;
        @(negedge clk);
        n_chk++; if (bus.mem_addr !== 30'h41) $display("FAIL rmid_new_addr: got %h want 41", bus.mem_addr); else n_pass++;
        @(negedge clk);
        n_chk++; if (rdata !== 32'hCAFEF00D) $display("FAIL rmid_new_rdata: got %h want cafef00d", rdata); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL rmid_new_done: got %b want 0", stall); else n_pass++;
        release_core();
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_errors();
        logic        rd_t[4];
        logic        wr_t[4];
        logic [1:0]  sel_t[4];
        logic [31:0] a_t[4];
        rd_t[0] = 1'b1; wr_t[0] = 1'b0; sel_t[0] = 2'b00; a_t[0] = 32'h101;
        rd_t[1] = 1'b0; wr_t[1] = 1'b1; sel_t[1] = 2'b01; a_t[1] = 32'h3;
        rd_t[2] = 1'b1; wr_t[2] = 1'b0; sel_t[2] = 2'b11; a_t[2] = 32'h0;
        rd_t[3] = 1'b1; wr_t[3] = 1'b1; sel_t[3] = 2'b00; a_t[3] = 32'h0;
        bus.mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(rd_t[k], wr_t[k], sel_t[k], 1'b0, a_t[k], 32'h0);
            #1;
            n_chk++; if (stall !== 1'b1) $display("FAIL err%0d_stall_idle: got %b want 1", k, stall); else n_pass++;
            @(negedge clk);
            n_chk++; if (acc_err !== 1'b1) $display("FAIL err%0d_acc_err: got %b want 1", k, acc_err); else n_pass++;
            n_chk++; if (stall !== 1'b0) $display("FAIL err%0d_stall_done: got %b want 0", k, stall); else n_pass++;
            n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL err%0d_req: got %b want 0", k, bus.mem_req); else n_pass++;
            n_chk++; if (rdata !== 32'h0) $display("FAIL err%0d_rdata: got %h want 0", k, rdata); else n_pass++;
            release_core();
            @(negedge clk);
            n_chk++; if (acc_err !== 1'b0) $display("FAIL err%0d_pulse: got %b want 0", k, acc_err); else n_pass++;
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'h55AA55AA);
        @(negedge clk);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.mem_req) break;
            n++;
            @(negedge clk);
        end
        n_chk++; if (n !== 16) $display("FAIL to_req_cycles: got %0d want 16", n); else n_pass++;
        n_chk++; if (acc_err !== 1'b1) $display("FAIL to_acc_err: got %b want 1", acc_err); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL to_stall: got %b want 0", stall); else n_pass++;
        release_core();
        bus.mem_ack = 1'b1;
        @(negedge clk);
        n_chk++; if (acc_err !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", acc_err); else n_pass++;
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL to_late_ack_req: got %b want 0", bus.mem_req); else n_pass++;
        @(negedge clk);
        n_chk++; if (stall !== 1'b0) $display("FAIL to_late_ack_stall: got %b want 0", stall); else n_pass++;
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL to_late_ack_req2: got %b want 0", bus.mem_req); else n_pass++;
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_lh_wait();
        test_reset_mid();
        test_errors();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-side responder for the load/store control signals produced by the instruction decoder: mem_read, mem_write, access size (AU_inst_sel) and signed_inst.
- Converts each load or store into a single word-wide request on a req/ack data-memory bus.
  - Stores: byte enables and lane replication.
  - Loads: lane extraction with sign/zero extension.
- Stalls the core until the access completes and flags misaligned, illegal or timed-out accesses.

Parameters:
- ADDR_W, 30, width of the word address on the memory bus; byte address bits [ADDR_W+1:2] are used.
- TIMEOUT, 16, maximum number of BUS-state cycles without mem_ack before the access is aborted; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load request from the control unit.
- mem_write  in  1  store request from the control unit.
- AU_inst_sel  in  2  access size: 00 word, 01 half, 10 byte, 11 illegal.
- signed_inst  in  1  loads: 1 sign-extend, 0 zero-extend; ignored for stores.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (rs2).
- rdata  out  32  load result, registered.
- stall  out  1  holds the core's PC/pipeline.
- acc_err  out  1  one-cycle pulse: misaligned, illegal size, mem_read&mem_write both high, or timeout.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  bus write, registered.
- mem_addr  out  ADDR_W  word address, registered.
- mem_be  out  4  byte enables, registered.
- mem_wdata  out  32  lane-replicated store data, registered.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  completion; may assert in the first mem_req cycle.

Behaviour:
- Interface contract: clk single clock; rst_n asynchronous active-low.
- Reset values:
  - State IDLE.
  - rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata, acc_err all 0.
  - stall 0 while rst_n=0.
  - Reset mid-access drops mem_req immediately; the access is abandoned.
- FSM states: IDLE, BUS, DONE.
- IDLE, with mem_read|mem_write=1:
  - Legality check:
    - mem_read and mem_write both 1 is illegal.
    - AU_inst_sel=11 is illegal.
    - Half access with addr[0]≠0 is misaligned.
    - Word access with addr[1:0]≠0 is misaligned.
  - Illegal or misaligned: no bus access; go to DONE with err flag set and rdata ← 0.
  - Legal: register mem_addr=addr[ADDR_W+1:2], mem_we, mem_be, mem_wdata; set mem_req=1; go to BUS.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- mem_wdata:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- BUS:
  - mem_req stays 1 and all bus outputs stay stable until mem_ack.
  - On mem_ack:
    - mem_req ← 0.
    - Loads capture the extracted, extended value into rdata.
    - Stores leave rdata unchanged.
    - Go to DONE.
  - Timeout counter counts BUS cycles. If TIMEOUT cycles pass without ack: mem_req ← 0, rdata ← 0, err flag set, go to DONE.
  - mem_ack outside BUS is ignored.
- DONE:
  - acc_err = err flag for exactly this cycle.
  - stall=0, so the core retires the instruction at the end of this cycle.
  - Next state IDLE unconditionally; the request is never re-accepted from DONE.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: bits [31:16] if addr[1], else [15:0].
  - Extend to 32 bits with the sign bit if signed_inst=1, with zeros otherwise.
- stall, combinational:
  - stall = (IDLE & (mem_read|mem_write)) | BUS.
  - DONE and an idle IDLE give 0.
- Latency:
  - Legal access with same-cycle ack: 3 cycles (IDLE, BUS, DONE), stall high for 2 of them.
  - Each extra ack wait cycle adds 1.
  - Error path without bus access: 2 cycles (IDLE, DONE).
- Core holds addr, wdata and the control inputs stable while stall=1; the block does not re-sample them after IDLE.

Test Plan:
- LW at addr 0x100, memory returns 0xDEADBEEF with ack in the first BUS cycle -> mem_addr=0x40, mem_be=1111, stall high 2 cycles, rdata=0xDEADBEEF in DONE, acc_err=0.
- LB signed at addr 0x103, mem_rdata=0x80FF_FF00 -> rdata=0xFFFFFF80; same access as LBU -> rdata=0x00000080.
- SH at addr 0x22 with wdata=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, rdata unchanged.
- LW at addr 0x101, then SH at 0x3, then AU_inst_sel=11 -> no mem_req, each gives a 1-cycle acc_err in DONE, stall high for 1 cycle.
- SW with mem_ack held low, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then drops; acc_err pulses; late ack ignored.
- Assert rst_n=0 in BUS cycle 3 of a load -> mem_req=0, stall=0, rdata=0 immediately; after release, a new LW completes normally.
